// File: rtl/conware_pkg.sv
// Shared definitions for the Life compute array: FSM state encoding and the
// fixed pipeline latencies the row feeder and its neighbours agree on.
package conware_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_e;

    // Frame memory read latency: rd_data is valid this many cycles after rd_en.
    localparam int RD_LAT = 1;

    // Cycles from row r's data cycle (rd_data returned) to its ns_valid.
    // din_row registers one cycle after the data cycle, so row r sits on
    // din_row NS_LAT-1 = 2 cycles before its next-state vector is valid.
    localparam int NS_LAT = 3;

    // Cycles spent in DRAIN after the bottom boundary slot is issued.
    localparam int DRAIN_CYCLES = 3;

endpackage

// File: rtl/row_feeder_if.sv
// Frame memory read port between the row feeder (master) and the frame
// memory (slave). rd_data is valid RD_LAT cycles after rd_en.
interface row_feeder_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/row_feeder.sv
// row_feeder: streams one board generation, row by row, from the frame
// memory into the column cells' shared serial input, adding the top and
// bottom boundary rows, and tags each next-state vector with its row index.
// Build option: define ROW_FEEDER_TORUS_WRAP_EN for a vertically wrapped
// (toroidal) board; otherwise the rows above and below the board are dead.
module row_feeder
    import conware_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    row_feeder_if.master      mem,
    output logic [WIDTH-1:0]  din_row,
    output logic              ns_valid,
    output logic [ADDR_W-1:0] ns_row,
    output logic [15:0]       gen_count
);

    // Slot counter covers 0..HEIGHT+1 in FEED and 0..DRAIN_CYCLES-1 in DRAIN.
    localparam int K_W = $clog2(HEIGHT + 2);
    localparam logic [K_W-1:0]    K_ONE      = K_W'(1);
    localparam logic [K_W-1:0]    H_K        = K_W'(HEIGHT);
    localparam logic [K_W-1:0]    LAST_SLOT  = K_W'(HEIGHT + 1);
    localparam logic [K_W-1:0]    DRAIN_LAST = K_W'(DRAIN_CYCLES - 1);
    localparam logic [K_W-1:0]    DONE_ARM   = K_W'(DRAIN_CYCLES - 2);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(HEIGHT - 1);
    // din_row is one register after the data cycle.
    localparam int DIN_TO_NS = NS_LAT - 1;

    fsm_state_e        state_q;
    logic [K_W-1:0]    k_q;
    logic [ADDR_W-1:0] base_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;

    // Per-slot flags for the slot being issued this cycle.
    logic              slot_vld_q;   // a slot of a pass is issued
    logic              slot_pad_q;   // slot supplies an all-zero row
    logic              slot_row_q;   // slot carries a board row (1..HEIGHT)

    // Same flags delayed to the data cycle.
    logic [RD_LAT-1:0] data_vld_q;
    logic [RD_LAT-1:0] data_pad_q;
    logic [RD_LAT-1:0] data_row_q;

    logic [WIDTH-1:0]     din_row_q;
    logic                 din_real_q;  // din_row holds a board row
    logic [DIN_TO_NS-1:0] ns_pipe_q;
    logic [ADDR_W-1:0]    ns_row_q;
    logic [ADDR_W-1:0]    ns_row_d;
    logic [15:0]          gen_count_q;
    logic [15:0]          gen_count_d;

    // What the next issued slot looks like.
    logic [K_W-1:0]    next_slot;
    logic [ADDR_W-1:0] issue_base;
    logic [ADDR_W-1:0] row_off;
    logic              is_row;
    logic              issue_rd;
    logic              issue_pad;
    logic [ADDR_W-1:0] issue_addr;

    // Decode the read strobe, address and pad flag for the next slot.
    always_comb begin
        // NOTE: every always_comb output is assigned a default first so no
        // path through the block can infer a latch.
        next_slot  = (state_q == ST_IDLE) ? '0 : k_q + K_ONE;
        issue_base = (state_q == ST_IDLE) ? base_addr : base_q;
        is_row     = (next_slot != '0) && (next_slot <= H_K);
        row_off    = ADDR_W'(next_slot - K_ONE);
`ifdef ROW_FEEDER_TORUS_WRAP_EN
        // Boundary slots fetch the opposite edge row of the board.
        issue_rd  = 1'b1;
        issue_pad = 1'b0;
        if (next_slot == '0) begin
            row_off = ROW_LAST;
        end else if (next_slot == LAST_SLOT) begin
            row_off = '0;
        end
`else
        // Boundary slots are dead rows: no read, zero data.
        issue_rd  = is_row;
        issue_pad = !is_row;
`endif
        issue_addr = issue_rd ? issue_base + row_off : '0;
    end

    // Pass sequencer: IDLE -> FEED (HEIGHT+2 slots) -> DRAIN -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            base_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            slot_vld_q <= 1'b0;
            slot_pad_q <= 1'b0;
            slot_row_q <= 1'b0;
        end else begin
            // NOTE: state is updated with <= only; combinational helpers
            // live in always_comb rather than as blocking temporaries here.
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_FEED;
                        base_q     <= base_addr;
                        k_q        <= '0;
                        busy_q     <= 1'b1;
                        rd_en_q    <= issue_rd;
                        rd_addr_q  <= issue_addr;
                        slot_vld_q <= 1'b1;
                        slot_pad_q <= issue_pad;
                        slot_row_q <= is_row;
                    end
                end
                ST_FEED: begin
                    if (k_q == LAST_SLOT) begin
                        state_q    <= ST_DRAIN;
                        k_q        <= '0;
                        rd_en_q    <= 1'b0;
                        rd_addr_q  <= '0;
                        slot_vld_q <= 1'b0;
                        slot_pad_q <= 1'b0;
                        slot_row_q <= 1'b0;
                    end else begin
                        k_q        <= next_slot;
                        rd_en_q    <= issue_rd;
                        rd_addr_q  <= issue_addr;
                        slot_vld_q <= 1'b1;
                        slot_pad_q <= issue_pad;
                        slot_row_q <= is_row;
                    end
                end
                ST_DRAIN: begin
                    if (k_q == DRAIN_LAST) begin
                        state_q <= ST_IDLE;
                        k_q     <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        k_q <= k_q + K_ONE;
                        // done lands on the last DRAIN cycle, with the last ns_valid.
                        if (k_q == DONE_ARM) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Carry slot flags to the data cycle, register din_row, delay to ns_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every pipeline stage is reset too, so a pass abandoned
            // by rst leaves no row or valid flag in flight.
            data_vld_q <= '0;
            data_pad_q <= '0;
            data_row_q <= '0;
            din_row_q  <= '0;
            din_real_q <= 1'b0;
            ns_pipe_q  <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                data_vld_q[i] <= data_vld_q[i-1];
                data_pad_q[i] <= data_pad_q[i-1];
                data_row_q[i] <= data_row_q[i-1];
            end
            data_vld_q[0] <= slot_vld_q;
            data_pad_q[0] <= slot_pad_q;
            data_row_q[0] <= slot_row_q;

            din_row_q  <= (data_vld_q[RD_LAT-1] && !data_pad_q[RD_LAT-1]) ? mem.rd_data : '0;
            din_real_q <= data_vld_q[RD_LAT-1] && data_row_q[RD_LAT-1];

            for (int i = DIN_TO_NS - 1; i > 0; i--) begin
                ns_pipe_q[i] <= ns_pipe_q[i-1];
            end
            ns_pipe_q[0] <= din_real_q;
        end
    end

    // Next values of the row tag and generation counters.
    always_comb begin
        ns_row_d    = ns_row_q;
        gen_count_d = gen_count_q;
        if (ns_pipe_q[DIN_TO_NS-1]) begin
            ns_row_d = (ns_row_q == ROW_LAST) ? '0 : ns_row_q + 1'b1;
        end
        if (done_q) begin
            gen_count_d = gen_count_q + 16'd1;
        end
    end

    // Row tag advances per next-state vector; generation count per pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            ns_row_q    <= '0;
            gen_count_q <= '0;
        end else begin
            ns_row_q    <= ns_row_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem.rd_en   = rd_en_q;
    assign mem.rd_addr = rd_addr_q;
    assign din_row     = din_row_q;
    assign ns_valid    = ns_pipe_q[DIN_TO_NS-1];
    assign ns_row      = ns_row_q;
    assign gen_count   = gen_count_q;

endmodule
